// File: rtl/clock_time_ctrl.sv
// clock_time_ctrl: time-of-day controller for the 7-segment clock.
// Keeps HH:MM:SS in BCD, advances on the 1 Hz enable, and lets the user
// set hours and minutes through a RUN / SET_HR / SET_MIN mode FSM driven
// by two debounced push-buttons.
module clock_time_ctrl #(
    parameter int INIT_HR  = 12,
    parameter int INIT_MIN = 0,
    parameter int BLINK_EN = 1
) (
    input  logic       mclk,
    input  logic       reset,
    input  logic       tick_1s,
    input  logic       btn_mode,
    input  logic       btn_inc,
    output logic [1:0] hr_t,
    output logic [3:0] hr_u,
    output logic [2:0] min_t,
    output logic [3:0] min_u,
    output logic [2:0] sec_t,
    output logic [3:0] sec_u,
    output logic [1:0] mode,
    output logic       blank_hr,
    output logic       blank_min,
    output logic       colon,
    output logic       day_wrap
);

    localparam logic [1:0] RUN     = 2'b00;
    localparam logic [1:0] SET_HR  = 2'b01;
    localparam logic [1:0] SET_MIN = 2'b10;

    localparam logic [1:0] INIT_HR_T  = 2'(INIT_HR / 10);
    localparam logic [3:0] INIT_HR_U  = 4'(INIT_HR % 10);
    localparam logic [2:0] INIT_MIN_T = 3'(INIT_MIN / 10);
    localparam logic [3:0] INIT_MIN_U = 4'(INIT_MIN % 10);

    logic [1:0] state;
    logic       phase;
    logic [2:0] mode_sr;
    logic [2:0] inc_sr;
    logic       mode_edge;
    logic       inc_edge;

    logic       sec_wrap;
    logic       min_wrap;
    logic       hr_wrap;
    logic [2:0] sec_t_inc;
    logic [3:0] sec_u_inc;
    logic [2:0] min_t_inc;
    logic [3:0] min_u_inc;
    logic [1:0] hr_t_inc;
    logic [3:0] hr_u_inc;

    // Two-stage synchroniser plus a third stage for rising-edge detection.
    always_ff @(posedge mclk or negedge reset) begin
        if (!reset) begin
            mode_sr <= 3'b000;
            inc_sr  <= 3'b000;
        end else begin
            mode_sr <= {mode_sr[1:0], btn_mode};
            inc_sr  <= {inc_sr[1:0], btn_inc};
        end
    end

    assign mode_edge = mode_sr[1] & ~mode_sr[2];
    assign inc_edge  = inc_sr[1] & ~inc_sr[2];

    // Incremented value of each BCD field together with its wrap flag.
    always_comb begin
        sec_wrap  = (sec_t == 3'd5) && (sec_u == 4'd9);
        min_wrap  = (min_t == 3'd5) && (min_u == 4'd9);
        hr_wrap   = (hr_t == 2'd2) && (hr_u == 4'd3);
        sec_u_inc = (sec_u == 4'd9) ? 4'd0 : sec_u + 4'd1;
        sec_t_inc = sec_wrap ? 3'd0 : ((sec_u == 4'd9) ? sec_t + 3'd1 : sec_t);
        min_u_inc = (min_u == 4'd9) ? 4'd0 : min_u + 4'd1;
        min_t_inc = min_wrap ? 3'd0 : ((min_u == 4'd9) ? min_t + 3'd1 : min_t);
        hr_u_inc  = (hr_wrap || hr_u == 4'd9) ? 4'd0 : hr_u + 4'd1;
        hr_t_inc  = hr_wrap ? 2'd0 : ((hr_u == 4'd9) ? hr_t + 2'd1 : hr_t);
    end

    // Mode FSM, time counters, blink phase, colon and day-wrap pulse.
    always_ff @(posedge mclk or negedge reset) begin
        if (!reset) begin
            state    <= RUN;
            phase    <= 1'b0;
            colon    <= 1'b1;
            day_wrap <= 1'b0;
            hr_t     <= INIT_HR_T;
            hr_u     <= INIT_HR_U;
            min_t    <= INIT_MIN_T;
            min_u    <= INIT_MIN_U;
            sec_t    <= 3'd0;
            sec_u    <= 4'd0;
        end else begin
            day_wrap <= 1'b0;
            case (state)
                RUN: begin
                    if (tick_1s) begin
                        sec_t <= sec_t_inc;
                        sec_u <= sec_u_inc;
                        if (sec_wrap) begin
                            min_t <= min_t_inc;
                            min_u <= min_u_inc;
                            if (min_wrap) begin
                                hr_t <= hr_t_inc;
                                hr_u <= hr_u_inc;
                                day_wrap <= hr_wrap;
                            end
                        end
                    end
                    if (mode_edge) begin
                        state <= SET_HR;
                        phase <= 1'b0;
                        colon <= 1'b1;
                    end else if (tick_1s) begin
                        colon <= ~colon;
                    end
                end
                SET_HR: begin
                    colon <= 1'b1;
                    if (mode_edge) begin
                        state <= SET_MIN;
                        phase <= 1'b0;
                    end else begin
                        if (inc_edge) begin
                            hr_t <= hr_t_inc;
                            hr_u <= hr_u_inc;
                        end
                        if (tick_1s) begin
                            phase <= ~phase;
                        end
                    end
                end
                SET_MIN: begin
                    colon <= 1'b1;
                    if (mode_edge) begin
                        state <= RUN;
                        phase <= 1'b0;
                        sec_t <= 3'd0;
                        sec_u <= 4'd0;
                    end else begin
                        if (inc_edge) begin
                            min_t <= min_t_inc;
                            min_u <= min_u_inc;
                        end
                        if (tick_1s) begin
                            phase <= ~phase;
                        end
                    end
                end
                default: begin
                    state <= RUN;
                    phase <= 1'b0;
                    colon <= 1'b1;
                end
            endcase
        end
    end

    assign mode      = state;
    assign blank_hr  = (BLINK_EN != 0) && (state == SET_HR) && phase;
    assign blank_min = (BLINK_EN != 0) && (state == SET_MIN) && phase;

endmodule

// File: doc/clock_time_ctrl.md
Name: clock_time_ctrl

Overview:
- Time-of-day controller for the clock design.
- Consumes the 1 Hz one-cycle enable from the 1-second tick generator and keeps HH:MM:SS in BCD.
- A 3-state mode FSM (RUN / SET_HR / SET_MIN) sequences the counter chain, with two push-buttons for user setting.
- Outputs drive the 7-segment decode/mux stage, including field-blank and colon-blink controls.

Parameters:
- INIT_HR, 12, hour loaded at reset (0..23, binary; converted to BCD internally)
- INIT_MIN, 0, minute loaded at reset (0..59)
- BLINK_EN, 1, 1 = blank the field being edited on alternate seconds; 0 = never blank

Ports:
- mclk  in  1  system clock, 50 MHz
- reset  in  1  asynchronous active-low reset
- tick_1s  in  1  one-mclk-cycle pulse, once per second, mclk domain
- btn_mode  in  1  debounced level, active-high, asynchronous to mclk
- btn_inc  in  1  debounced level, active-high, asynchronous to mclk
- hr_t  out  2  hours tens BCD
- hr_u  out  4  hours units BCD
- min_t  out  3  minutes tens BCD
- min_u  out  4  minutes units BCD
- sec_t  out  3  seconds tens BCD
- sec_u  out  4  seconds units BCD
- mode  out  2  00 RUN, 01 SET_HR, 10 SET_MIN (11 never driven)
- blank_hr  out  1  blank hour digits
- blank_min  out  1  blank minute digits
- colon  out  1  colon segment enable
- day_wrap  out  1  one-cycle pulse on 23:59:59 -> 00:00:00

Behaviour:
- Decided interface: reset is asynchronous, active-low; clock is mclk. All state updates on posedge mclk.
- Reset values:
  - time = INIT_HR:INIT_MIN:00
  - mode = RUN
  - blank_hr = blank_min = 0, colon = 1, day_wrap = 0
  - blink phase = 0, sync/edge registers = 0
- Button input path:
  - Each button goes through a 2-FF synchroniser, then a rising-edge detect against a third register.
  - A button rising before edge k produces an action at edge k+2; this latency is fixed.
  - Holding a button gives exactly one action; there is no auto-repeat.
- FSM:
  - RUN --mode_edge--> SET_HR --mode_edge--> SET_MIN --mode_edge--> RUN.
  - Leaving SET_MIN clears seconds to 00 on the same edge.
- RUN:
  - tick_1s advances the BCD chain: sec 59 -> 00 carries to min; min 59 -> 00 carries to hr; hr 23 -> 00.
  - day_wrap = 1 for exactly the cycle after the edge that performs 23:59:59 -> 00:00:00.
  - colon toggles on each tick_1s.
  - inc_edge is ignored.
- SET_HR:
  - inc_edge: hr + 1, 23 -> 00 wrap; no effect on min or sec.
  - tick_1s does not advance time; it toggles blink phase.
- SET_MIN:
  - inc_edge: min + 1, 59 -> 00 wrap, no carry into hr.
  - tick_1s toggles blink phase only.
- Set-mode outputs:
  - colon = 1 steady in both set states.
  - blank_hr = BLINK_EN & (mode == SET_HR) & phase.
  - blank_min is the same term with SET_MIN.
  - Blink phase clears to 0 on every mode transition, so the edited field is visible immediately.
- Simultaneous events in one cycle:
  - tick_1s + mode_edge in RUN: time advances AND state moves to SET_HR.
  - tick_1s + mode_edge in SET_MIN: seconds cleared to 00, no advance.
  - mode_edge + inc_edge: mode wins; inc is discarded.
  - tick_1s + inc_edge in a set state: both apply (increment and phase toggle).
- Invariants:
  - BCD digits never exceed legal values.
  - Hours tens = 2 implies units ≤ 3.
  - Outputs are registered, not combinational from inputs.
- Reset mid-operation: asserting reset in any state returns immediately (asynchronously) to reset values. Pending button edges are lost.

Test Plan:
- Reset with INIT_HR=12, INIT_MIN=0 -> outputs 12:00:00, mode=00, colon=1, blanks=0, day_wrap=0. Releasing reset with no tick -> unchanged.
- RUN with 60 tick_1s pulses spaced 5 cycles -> 12:01:00. colon has toggled 60 times (ends at 1). No day_wrap.
- INIT_HR=23, INIT_MIN=59, then 59 ticks -> 23:59:59. Next tick -> 00:00:00 with day_wrap high exactly one cycle.
- Set sequence from 12:00:37:
  - mode press -> mode=01 at edge k+2.
  - 13 inc presses -> hr 01 (wrap through 23).
  - mode -> mode=10; 60 inc -> min 00, hr still 01.
  - mode -> RUN at 01:00:00.
  - blank_hr/blank_min alternate with ticks only in their own state.
- btn_mode and tick_1s rising so their actions coincide in RUN at 12:00:05 -> 12:00:06 and mode=01. mode+inc coincident in SET_HR -> mode=10, hr unchanged.
- Reset asserted mid-SET_MIN with min edited to 45 -> immediate return to INIT time, mode=00, blank_min=0. A held btn_inc across reset release -> no increment.
